// File: rtl/memory_pkg.sv
// Shared constants and types for the general-purpose data memory.
package memory_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] addr_t;

endpackage

// File: rtl/memory_array.sv
// Storage array for the data memory: async clear and synchronous write port.
module memory_array
  import memory_pkg::*;
#(
  parameter int unsigned DATA_W = memory_pkg::DATA_W,
  parameter int unsigned ADDR_W = memory_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in,
  input  logic [ADDR_W-1:0] address,
  input  logic              write,
  output logic [DATA_W-1:0] mem [1 << ADDR_W]
);

  localparam int unsigned NWORDS = 1 << ADDR_W;

  // Clear every word on reset; otherwise store in at address when write is set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NWORDS; i++) begin
        mem[i] <= '0;
      end
    end else if (write) begin
      mem[address] <= in;
    end
  end

endmodule

// File: rtl/memory.sv
// Single-port data memory, 2^ADDR_W x DATA_W, synchronous write.
// Read path is combinational unless MEMORY_OUT_REG_EN is defined, in which
// case out is a register loaded with mem[address] every clock (1-cycle read).
module memory
  import memory_pkg::*;
#(
  parameter int unsigned DATA_W = memory_pkg::DATA_W,
  parameter int unsigned ADDR_W = memory_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in,
  input  logic [ADDR_W-1:0] address,
  input  logic              write,
  output logic [DATA_W-1:0] out
);

  logic [DATA_W-1:0] mem [1 << ADDR_W];
  logic [DATA_W-1:0] rd_data_c;

  memory_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .in      (in),
    .address (address),
    .write   (write),
    .mem     (mem)
  );

  // Read mux: select the addressed word.
  always_comb begin
    rd_data_c = mem[address];
  end

`ifdef MEMORY_OUT_REG_EN
  // Registered read: sample the addressed word (pre-write contents) each edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= '0;
    end else begin
      out <= rd_data_c;
    end
  end
`else
  // Combinational read: out follows address and storage directly.
  always_comb begin
    out = rd_data_c;
  end
`endif

endmodule

// File: tb/tb_memory.sv
// Self-checking bench for memory against an array-based reference model.
module tb_memory;
  import memory_pkg::*;

  logic  clk = 1'b0;
  logic  rst_n;
  data_t in;
  addr_t address;
  logic  write;
  data_t out;

  int checks   = 0;
  int failures = 0;

  // Reference model: the whole store as a plain array, plus the expected
  // registered read value for the output-register build.
  data_t ref_mem [DEPTH];
  data_t exp_reg;

  memory dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in      (in),
    .address (address),
    .write   (write),
    .out     (out)
  );

  always #5 clk = ~clk;

  function automatic data_t exp_out();
`ifdef MEMORY_OUT_REG_EN
    return exp_reg;
`else
    return ref_mem[address];
`endif
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = '0;
    exp_reg = '0;
  endfunction

  // One clock: model the rising edge using current inputs, then resume at negedge.
  task automatic step();
    if (rst_n) begin
      exp_reg = ref_mem[address];
      if (write) ref_mem[address] = in;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; write = 1'b0; in = '0; address = 8'd42;
    model_clear();
    #1;
    checks++;
    if (out !== 8'h00) begin
      failures++; $display("FAIL reset_out got=%h want=%h", out, 8'h00);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++;
    if (out !== exp_out() || out !== 8'h00) begin
      failures++; $display("FAIL post_reset_read42 got=%h want=%h", out, exp_out());
    end
  endtask

  task automatic test_write_read();
    address = 8'd23; in = 8'd23; write = 1'b1;
    step();
    write = 1'b0;
    step();
    checks++;
    if (out !== exp_out() || out !== 8'd23) begin
      failures++; $display("FAIL write23_read got=%h want=%h", out, 8'd23);
    end
    address = 8'd42;
`ifndef MEMORY_OUT_REG_EN
    #1;
    checks++;
    if (out !== ref_mem[42]) begin
      failures++; $display("FAIL comb_addr_change got=%h want=%h", out, ref_mem[42]);
    end
`endif
    step();
    checks++;
    if (out !== exp_out() || out !== 8'h00) begin
      failures++; $display("FAIL read42 got=%h want=%h", out, exp_out());
    end
    address = 8'd23;
    step();
    checks++;
    if (out !== exp_out()) begin
      failures++; $display("FAIL reread23 got=%h want=%h", out, exp_out());
    end
  endtask

  task automatic test_no_write();
    address = 8'd7; in = 8'h55; write = 1'b0;
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (out !== exp_out() || out !== 8'h00) begin
      failures++; $display("FAIL nowrite7 got=%h want=%h", out, exp_out());
    end
  endtask

  task automatic test_boundary();
    address = 8'd255; in = 8'hFF; write = 1'b1;
    step();
    address = 8'd0; in = 8'h01;
    step();
    write = 1'b0; in = 8'hA5;
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: address = 8'd255;
        1: address = 8'd0;
        2: address = 8'd254;
        default: address = 8'd1;
      endcase
      step();
      checks++;
      if (out !== exp_out()) begin
        failures++; $display("FAIL boundary_addr%0d got=%h want=%h", address, out, exp_out());
      end
    end
  endtask

  task automatic test_back_to_back();
    address = 8'd9; in = 8'hAA; write = 1'b1;
    step();
    in = 8'h3C;
    step();
    write = 1'b0;
    step();
    checks++;
    if (out !== exp_out() || out !== 8'h3C) begin
      failures++; $display("FAIL b2b_addr9 got=%h want=%h", out, 8'h3C);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      address = addr_t'($urandom_range(0, 15));
      if (i % 3 == 0) address = addr_t'($urandom);
      in    = data_t'($urandom);
      write = 1'($urandom_range(0, 1));
      step();
      checks++;
      if (out !== exp_out()) begin
        failures++; $display("FAIL random_%0d addr=%0d got=%h want=%h", i, address, out, exp_out());
      end
    end
    write = 1'b0;
  endtask

  task automatic test_reset_mid();
    address = 8'd23; in = 8'h77; write = 1'b1;
    #2 rst_n = 1'b0;
    model_clear();
    #1;
    checks++;
    if (out !== 8'h00) begin
      failures++; $display("FAIL reset_mid_out got=%h want=%h", out, 8'h00);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; write = 1'b0;
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: address = 8'd23;
        1: address = 8'd9;
        default: address = 8'd255;
      endcase
      step();
      checks++;
      if (out !== exp_out() || out !== 8'h00) begin
        failures++; $display("FAIL reset_mid_addr%0d got=%h want=%h", address, out, 8'h00);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_no_write();
    test_boundary();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
